// File: rtl/tt_um_rodschz_subtractor04.sv
// Bit-serial 4-bit subtractor TinyTapeout macro: D = (S - A) mod 16 with borrow,
// computed LSB-first over four clocks after a start edge on uio[0].
module tt_um_rodschz_subtractor04 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e      state_q;
  logic        start_q;
  logic [3:0]  sreg_q;
  logic [3:0]  areg_q;
  logic [3:0]  diff_sr_q;
  logic        borrow_acc_q;
  logic [2:0]  idx_q;
  logic [3:0]  diff_q;
  logic        borrow_q;
  logic        busy_q;
  logic        done_q;

  logic        start_edge;
  logic        s0;
  logic        a0;
  logic        d_bit;
  logic        borrow_d;
  logic [3:0]  diff_sr_d;

  assign start_edge = uio_in[0] & ~start_q & ena;

  // One full-subtractor slice applied to the current LSBs.
  always_comb begin
    s0        = sreg_q[0];
    a0        = areg_q[0];
    d_bit     = s0 ^ a0 ^ borrow_acc_q;
    borrow_d  = (~s0 & a0) | (~(s0 ^ a0) & borrow_acc_q);
    diff_sr_d = {d_bit, diff_sr_q[3:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      sreg_q       <= 4'd0;
      areg_q       <= 4'd0;
      diff_sr_q    <= 4'd0;
      borrow_acc_q <= 1'b0;
      idx_q        <= 3'd0;
      diff_q       <= 4'd0;
      borrow_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      start_q <= uio_in[0];
      case (state_q)
        StIdle, StDone: begin
          if (start_edge) begin
            sreg_q       <= ui_in[7:4];
            areg_q       <= ui_in[3:0];
            diff_sr_q    <= 4'd0;
            borrow_acc_q <= 1'b0;
            idx_q        <= 3'd0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= StShift;
          end
        end
        StShift: begin
          borrow_acc_q <= borrow_d;
          diff_sr_q    <= diff_sr_d;
          sreg_q       <= {1'b0, sreg_q[3:1]};
          areg_q       <= {1'b0, areg_q[3:1]};
          idx_q        <= idx_q + 3'd1;
          // Result registers only change on the final slice.
          if (idx_q == 3'd3) begin
            diff_q   <= diff_sr_d;
            borrow_q <= borrow_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uo_out  = {1'b0, done_q, busy_q, borrow_q, diff_q};
  assign uio_out = {4'b0000, idx_q, 1'b0};
  assign uio_oe  = 8'b1111_1110;

  logic unused_pins;
  assign unused_pins = ^uio_in[7:1];

endmodule

// File: tb/tb_tt_um_rodschz_subtractor04.sv
// Directed self-checking bench for the bit-serial 4-bit subtractor macro.
module tb_tt_um_rodschz_subtractor04;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_fails;
  logic [4:0] prev_res;

  tt_um_rodschz_subtractor04 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    chk("uio_oe", {24'd0, uio_oe}, 32'hFE);
    chk("const_bits", {29'd0, uo_out[7], uio_out[0], |uio_out[7:4]}, 32'd0);
  endtask

  task automatic run_op(input logic [3:0] s, input logic [3:0] a, input logic [7:0] exp_uo,
                        input string tag);
    ui_in     = {s, a};
    uio_in[0] = 1'b1;
    step();
    chk({tag, "/e0_flags"}, {30'd0, uo_out[6:5]}, 32'd1);
    chk({tag, "/e0_idx"}, {29'd0, uio_out[3:1]}, 32'd0);
    uio_in[0] = 1'b0;
    ui_in     = 8'($urandom);
    for (int i = 1; i < 4; i++) begin
      step();
      chk({tag, "/busy"}, {30'd0, uo_out[6:5]}, 32'd1);
      chk({tag, "/idx"}, {29'd0, uio_out[3:1]}, 32'(i));
      chk({tag, "/hold"}, {27'd0, uo_out[4:0]}, {27'd0, prev_res});
      ui_in = 8'($urandom);
    end
    step();
    chk({tag, "/result"}, {24'd0, uo_out}, {24'd0, exp_uo});
    chk({tag, "/idx4"}, {29'd0, uio_out[3:1]}, 32'd4);
    prev_res = exp_uo[4:0];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    logic [7:0] exp_uo;
    n_checks = 0;
    n_fails  = 0;
    prev_res = 5'd0;
    rst_n    = 1'b0;
    ena      = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;
    repeat (2) step();
    chk("reset_uo", {24'd0, uo_out}, 32'd0);
    chk("reset_uio", {24'd0, uio_out}, 32'd0);
    rst_n = 1'b1;
    step();

    run_op(4'd9, 4'd5, 8'h44, "s9a5");
    repeat (3) begin
      step();
      chk("s9a5/stay", {24'd0, uo_out}, 32'h44);
    end
    run_op(4'd3, 4'd7, 8'h5C, "s3a7");
    run_op(4'd15, 4'd15, 8'h40, "s15a15");

    for (int s = 0; s < 16; s++) begin
      for (int a = 0; a < 16; a++) begin
        exp_uo = {3'b010, (a > s) ? 1'b1 : 1'b0, 4'((s - a) & 15)};
        run_op(4'(s), 4'(a), exp_uo, "sweep");
      end
    end

    // Start held high: only the first edge counts.
    ui_in     = {4'd6, 4'd2};
    uio_in[0] = 1'b1;
    busy_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (uo_out[5]) busy_cnt++;
    end
    chk("held/busy_cycles", 32'(busy_cnt), 32'd4);
    chk("held/result", {24'd0, uo_out}, 32'h44);
    uio_in[0] = 1'b0;
    step();

    // Re-pulse during SHIFT is ignored; done at the original fourth edge.
    ui_in     = {4'd2, 4'd5};
    uio_in[0] = 1'b1;
    step();
    uio_in[0] = 1'b0;
    step();
    uio_in[0] = 1'b1;
    step();
    uio_in[0] = 1'b0;
    step();
    chk("repulse/e3_busy", {30'd0, uo_out[6:5]}, 32'd1);
    step();
    chk("repulse/e4", {24'd0, uo_out}, 32'h5D);
    chk("repulse/idx", {29'd0, uio_out[3:1]}, 32'd4);
    repeat (2) step();
    chk("repulse/after", {24'd0, uo_out}, 32'h5D);
    prev_res = 5'h1D;

    // ena low masks the start edge.
    ena       = 1'b0;
    ui_in     = {4'd1, 4'd1};
    uio_in[0] = 1'b1;
    repeat (3) begin
      step();
      chk("ena0/uo", {24'd0, uo_out}, 32'h5D);
    end
    uio_in[0] = 1'b0;
    step();
    ena = 1'b1;
    step();
    chk("ena0/still", {24'd0, uo_out}, 32'h5D);

    // Asynchronous reset between edges at idx=2.
    ui_in     = {4'd12, 4'd3};
    uio_in[0] = 1'b1;
    step();
    uio_in[0] = 1'b0;
    repeat (2) step();
    chk("areset/idx2", {29'd0, uio_out[3:1]}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset/uo", {24'd0, uo_out}, 32'd0);
    chk("areset/uio", {24'd0, uio_out}, 32'd0);
    step();
    rst_n    = 1'b1;
    prev_res = 5'd0;
    step();
    run_op(4'd8, 4'd1, 8'h47, "s8a1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
